conv33_output_sink: RTL and testbench

//  Receiving end of the conv33 compute output stream: captures each word the compute top

---
 rtl/conv33_pkg.sv | 16 +
 rtl/conv33_output_sink_if.sv | 31 +++
 rtl/conv33_sink_fifo.sv | 58 +++++
 rtl/conv33_output_sink.sv | 89 ++++++++
 tb/tb_conv33_output_sink.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/conv33_pkg.sv
// Shared constants and helpers for the conv33 output sink: frame geometry and the FIFO entry layout.
package conv33_pkg;

  localparam int WIDTH_DEF = 16;

  // A 3x3 valid-mode convolution loses one pixel on every border.
  function automatic int out_dim(input int img_dim);
    return img_dim - 2;
  endfunction

  typedef struct packed {
    logic                 last;
    logic [WIDTH_DEF-1:0] data;
  } sink_entry_t;

endpackage

// File: rtl/conv33_output_sink_if.sv
// Producer strobe/data plus the drain valid/ready port of the conv33 output sink.
// Drain handshake: a word transfers on every rising edge where drain_valid=1 and drain_ready=1;
// while drain_valid=1 and drain_ready=0 the sink holds drain_data/drain_last stable.
interface conv33_output_sink_if #(
  parameter int WIDTH = 16
);
  logic             out_inst_output_write_valid;
  logic [WIDTH-1:0] out_inst_output_write [0:0];
  logic             drain_valid;
  logic             drain_ready;
  logic [WIDTH-1:0] drain_data;
  logic             drain_last;

  modport master (
    output out_inst_output_write_valid,
    output out_inst_output_write,
    output drain_ready,
    input  drain_valid,
    input  drain_data,
    input  drain_last
  );

  modport slave (
    input  out_inst_output_write_valid,
    input  out_inst_output_write,
    input  drain_ready,
    output drain_valid,
    output drain_data,
    output drain_last
  );
endinterface

// File: rtl/conv33_sink_fifo.sv
// Single-clock flop-array FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module conv33_sink_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  output logic                     full,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      // When full with a pop, wptr equals rptr: the new word lands in the slot being vacated.
      if (do_push) mem_q[wptr_q] <= din;
    end
  end
endmodule

// File: rtl/conv33_output_sink.sv
// Captures conv33 output words, tags frame position, buffers them and drains to the host.
module conv33_output_sink
  import conv33_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv33_output_sink_if.slave  bus,
  output logic                 frame_done,
  output logic                 overflow,
  output logic [15:0]          frame_count
);
  localparam int OUT_W = out_dim(IMG_W);
  localparam int OUT_H = out_dim(IMG_H);
  localparam int CW    = $clog2(OUT_W + 1);
  localparam int RW    = $clog2(OUT_H + 1);

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_done_q, frame_done_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   push, pop, at_last_col, at_last_row;
  logic                   fifo_full, fifo_empty;
  logic [WIDTH:0]         fifo_din, fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;

  assign push        = bus.out_inst_output_write_valid;
  assign at_last_col = (col_q == CW'(OUT_W - 1));
  assign at_last_row = (row_q == RW'(OUT_H - 1));
  assign fifo_din    = {at_last_col & at_last_row, bus.out_inst_output_write[0]};
  assign pop         = bus.drain_valid & bus.drain_ready;

  conv33_sink_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.drain_valid = (fifo_count != '0);
  assign bus.drain_data  = fifo_empty ? '0 : fifo_dout[WIDTH-1:0];
  assign bus.drain_last  = ~fifo_empty & fifo_dout[WIDTH];
  assign frame_done      = frame_done_q;
  assign overflow        = overflow_q;
  assign frame_count     = frame_count_q;

  // Position advances on every strobe, dropped or not, so the frame stays aligned.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    overflow_d    = overflow_q | (push & fifo_full & ~pop);
    frame_done_d  = pop & fifo_dout[WIDTH];
    frame_count_d = frame_count_q + {15'd0, frame_done_d};
    if (push) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      row_q         <= '0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule

// File: tb/tb_conv33_output_sink.sv
// Bench for conv33_output_sink with a 3x3 output frame (IMG 5x5) and a 4-entry FIFO.
module tb_conv33_output_sink;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PIX   = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        frame_done, overflow;
  logic [15:0] frame_count;

  conv33_output_sink_if #(.WIDTH(WIDTH)) bus ();

  conv33_output_sink #(.WIDTH(WIDTH), .IMG_W(5), .IMG_H(5), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of {last,data} words plus a frame pixel index.
  logic [WIDTH:0] exp_q[$];
  int             idx = 0;
  bit             m_ovf = 0;
  bit             m_fd = 0;
  logic [15:0]    m_fc = '0;
  logic [WIDTH:0] head;
  bit             m_pop;

  logic [WIDTH:0] log_q[$];
  logic [WIDTH:0] want_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      idx = 0; m_ovf = 0; m_fd = 0; m_fc = '0;
    end else begin
      m_pop = (exp_q.size() != 0) && bus.drain_ready;
      m_fd = 0;
      if (m_pop) begin
        head = exp_q.pop_front();
        if (head[WIDTH]) begin m_fd = 1; m_fc = m_fc + 16'd1; end
      end
      if (bus.out_inst_output_write_valid) begin
        if (exp_q.size() == DEPTH) m_ovf = 1;
        else exp_q.push_back({idx == PIX - 1, bus.out_inst_output_write[0]});
        idx = (idx + 1) % PIX;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("drain_valid", 32'(bus.drain_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("drain_data", 32'(bus.drain_data), 32'(exp_q[0][WIDTH-1:0]));
        check("drain_last", 32'(bus.drain_last), 32'(exp_q[0][WIDTH]));
      end
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("frame_count", 32'(frame_count), 32'(m_fc));
      if (bus.drain_valid && bus.drain_ready) log_q.push_back({bus.drain_last, bus.drain_data});
    end
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bus.out_inst_output_write_valid = v;
    bus.out_inst_output_write[0]    = d;
    bus.drain_ready                 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.out_inst_output_write_valid = 1'b0;
    bus.drain_ready = 1'b0;
    #1;
    check("rst drain_valid", 32'(bus.drain_valid), 0);
    check("rst drain_data", 32'(bus.drain_data), 0);
    check("rst drain_last", 32'(bus.drain_last), 0);
    check("rst frame_done", 32'(frame_done), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst frame_count", 32'(frame_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic check_log(input string name);
    check({name, " count"}, 32'(log_q.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < log_q.size(); i++)
      check(name, 32'(log_q[i]), 32'(want_q[i]));
    want_q.delete();
    log_q.delete();
  endtask

  initial begin
    bus.out_inst_output_write_valid = 1'b0;
    bus.out_inst_output_write[0]    = '0;
    bus.drain_ready                 = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single frame streamed straight through.
    for (int i = 1; i <= 9; i++) cyc(1'b1, 16'(i), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 1; i <= 9; i++) want_q.push_back({i == 9, 16'(i)});
    check_log("t1 order");
    check("t1 frame_count", 32'(frame_count), 1);

    // Overflow: fifth word dropped while blocked.
    for (int i = 10; i <= 14; i++) cyc(1'b1, 16'(i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("t2 overflow", 32'(overflow), 1);
    check("t2 held valid", 32'(bus.drain_valid), 1);
    check("t2 held data", 32'(bus.drain_data), 10);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 10; i <= 13; i++) want_q.push_back({1'b0, 16'(i)});
    check_log("t2 drain");

    // Push while full and popping in the same cycle.
    do_reset();
    for (int i = 15; i <= 18; i++) cyc(1'b1, 16'(i), 1'b0);
    cyc(1'b1, 16'd20, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1);
    check("t3 overflow", 32'(overflow), 0);
    for (int i = 15; i <= 18; i++) want_q.push_back({1'b0, 16'(i)});
    want_q.push_back({1'b0, 16'd20});
    check_log("t3 order");

    // Two back-to-back frames with toggling ready.
    do_reset();
    for (int c = 0; c < 36; c++) cyc(c % 2 == 0, 16'(c / 2 + 1), c % 2 == 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 1; i <= 18; i++) want_q.push_back({(i == 9) || (i == 18), 16'(i)});
    check_log("t4 order");
    check("t4 frame_count", 32'(frame_count), 2);
    check("t4 overflow", 32'(overflow), 0);

    // Asynchronous reset mid-frame restarts tagging at pixel (0,0).
    for (int i = 1; i <= 5; i++) cyc(1'b1, 16'(16'h100 + i), 1'b0);
    #2;
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 16'(16'h200 + i), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 1; i <= 9; i++) want_q.push_back({i == 9, 16'(16'h200 + i)});
    check_log("t5 order");
    check("t5 frame_count", 32'(frame_count), 1);

    // Head held stable under backpressure.
    do_reset();
    cyc(1'b1, 16'h00a5, 1'b0);
    cyc(1'b1, 16'h005a, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, 1'b0);
      check("t6 hold valid", 32'(bus.drain_valid), 1);
      check("t6 hold data", 32'(bus.drain_data), 32'h00a5);
      check("t6 hold last", 32'(bus.drain_last), 0);
      check("t6 frame_done", 32'(frame_done), 0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    want_q.push_back({1'b0, 16'h00a5});
    want_q.push_back({1'b0, 16'h005a});
    check_log("t6 drain");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    check("rand drained", 32'(bus.drain_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
